// File: rtl/cha_map_pkg.sv
// rtl/cha_map_pkg.sv - shared state type, table entry type, default entry and per-build game table
package cha_map_pkg;

  localparam int DEF_BANK_W = 7;
  localparam int DEF_IX_W   = 11;

  typedef enum logic [1:0] {HOLD, SETTLE, LOOKUP, RUN} state_t;

  typedef struct packed {
    logic [DEF_BANK_W-2:0] mask;
    logic [DEF_IX_W-1:0]   ix;
  } ix_entry_t;

  localparam ix_entry_t DEFAULT_ENTRY = {{(DEF_BANK_W-1){1'b1}}, {DEF_IX_W{1'b0}}};

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  // Per-build game table; any game not listed falls back to DEFAULT_ENTRY.
  function automatic ix_entry_t game_entry(input int unsigned gsel);
    ix_entry_t e;
    e = DEFAULT_ENTRY;
    case (gsel)
      3:       e = {6'b000111, 11'd40};
      4:       e = {6'b111111, 11'h600};
      6:       e = {6'b111111, 11'd2047};
      default: e = DEFAULT_ENTRY;
    endcase
    return e;
  endfunction

endpackage

// File: rtl/cha_ix_rom.sv
// rtl/cha_ix_rom.sv - synchronous-read MASK/IX table indexed by game select, one cycle latency
module cha_ix_rom
  import cha_map_pkg::*;
#(
  parameter int GSEL_W = 8,
  parameter int BANK_W = 7,
  parameter int IX_W   = 11
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [GSEL_W-1:0] gsel,
  output logic [BANK_W-2:0] mask,
  output logic [IX_W-1:0]   ix
);

  ix_entry_t entry;

  always_comb begin
    entry = game_entry(32'(gsel));
  end

  // Default entries keep an all-ones mask whatever the build's bank width.
  always_ff @(posedge clk) begin
    if (reset) begin
      mask <= '1;
      ix   <= '0;
    end else begin
      mask <= (entry == DEFAULT_ENTRY) ? '1 : (BANK_W-1)'(entry.mask);
      ix   <= IX_W'(entry.ix);
    end
  end

endmodule

// File: rtl/cha_map_gen.sv
// rtl/cha_map_gen.sv - clocked C-ROM address mapper: strobe sync, bank latch, game lookup FSM, chip enables
module cha_map_gen
  import cha_map_pkg::*;
#(
  parameter int GSEL_W     = 8,
  parameter int BANK_W     = 7,
  parameter int IX_W       = 11,
  parameter int NUM_CHIPS  = 2,
  parameter int SETTLE_CYC = 16
) (
  input  logic                                CLK_12M,
  input  logic                                RESET,
  input  logic                                PCK1B,
  input  logic [BANK_W-1:0]                   PBUS_BANK,
  input  logic [GSEL_W-1:0]                   GSEL,
  output logic [IX_W-clog2(NUM_CHIPS)-1:0]    C_ADDR,
  output logic [2*NUM_CHIPS-1:0]              C_nOE,
  output logic                                READY,
  output logic                                MAP_OVF
);

  localparam int CS_W  = clog2(NUM_CHIPS);
  localparam int NOE_W = 2 * NUM_CHIPS;
  localparam int CNT_W = clog2(SETTLE_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(SETTLE_CYC - 1);

  logic              sync1, sync2, sync3;
  logic              strb;
  logic [BANK_W-1:0] bank_d1, bank_d2, bank_latch;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [GSEL_W-1:0] gsel_q;
  logic [BANK_W-2:0] mask_q, rom_mask;
  logic [IX_W-1:0]   ix_q, rom_ix;

  logic [IX_W:0]     sum_full;
  logic [IX_W:0]     map_all;
  logic [CS_W:0]     oe_idx;
  logic [NOE_W-1:0]  noe_onehot;

  cha_ix_rom #(
    .GSEL_W (GSEL_W),
    .BANK_W (BANK_W),
    .IX_W   (IX_W)
  ) u_rom (
    .clk   (CLK_12M),
    .reset (RESET),
    .gsel  (GSEL),
    .mask  (rom_mask),
    .ix    (rom_ix)
  );

  assign strb = sync2 & ~sync3;

  // Bank bits ride two flops alongside the strobe synchroniser so they line up with strb.
  always_ff @(posedge CLK_12M) begin
    if (RESET) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      sync3      <= 1'b0;
      bank_d1    <= '0;
      bank_d2    <= '0;
      bank_latch <= '0;
    end else begin
      sync1   <= PCK1B;
      sync2   <= sync1;
      sync3   <= sync2;
      bank_d1 <= PBUS_BANK;
      bank_d2 <= bank_d1;
      if (strb) bank_latch <= bank_d2;
    end
  end

  assign sum_full   = {1'b0, ix_q} + (IX_W+1)'(bank_latch[BANK_W-1:1] & mask_q);
  assign map_all    = {sum_full[IX_W-1:0], bank_latch[0]};
  assign oe_idx     = map_all[IX_W -: CS_W+1];
  assign noe_onehot = NOE_W'(1) << oe_idx;

  always_ff @(posedge CLK_12M) begin
    if (RESET) begin
      state   <= HOLD;
      cnt     <= '0;
      gsel_q  <= '0;
      mask_q  <= '1;
      ix_q    <= '0;
      C_ADDR  <= '0;
      C_nOE   <= '1;
      READY   <= 1'b0;
      MAP_OVF <= 1'b0;
    end else begin
      gsel_q <= GSEL;

      if (state == RUN) begin
        C_ADDR <= map_all[IX_W-CS_W-1:0];
        C_nOE  <= ~noe_onehot;
        if (sum_full[IX_W]) MAP_OVF <= 1'b1;
      end else begin
        C_nOE <= '1;
      end

      case (state)
        HOLD: begin
          READY <= 1'b0;
          if (GSEL != '0) begin
            state <= SETTLE;
            cnt   <= CNT_LOAD;
          end
        end
        SETTLE: begin
          if (GSEL == '0)          state <= HOLD;
          else if (GSEL != gsel_q) cnt   <= CNT_LOAD;
          else if (cnt == '0)      state <= LOOKUP;
          else                     cnt   <= cnt - 1'b1;
        end
        LOOKUP: begin
          mask_q  <= rom_mask;
          ix_q    <= rom_ix;
          MAP_OVF <= 1'b0;
          READY   <= 1'b1;
          state   <= RUN;
        end
        RUN: begin
          if (GSEL == '0) begin
            state <= HOLD;
            READY <= 1'b0;
          end else if (GSEL != gsel_q) begin
            state <= SETTLE;
            cnt   <= CNT_LOAD;
            READY <= 1'b0;
          end
        end
        default: state <= HOLD;
      endcase
    end
  end

endmodule
